// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the serial stream front end.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DEF_DATA_W   = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serializer_hold_reg.sv
// One-entry holding register: a write fills it, a read-consume empties it.
module serializer_hold_reg
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // Payload carries no reset; full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q <= wr_data;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding slot for gapless streaming.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   DATA_W    = DEF_DATA_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  function automatic logic head_bit(input logic [DATA_W-1:0] s);
    return MSB_FIRST ? s[DATA_W-1] : s[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
    return MSB_FIRST ? {s[DATA_W-2:0], 1'b0} : {1'b0, s[DATA_W-1:1]};
  endfunction

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt, pend_data;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              pend_full, accept, last_bit, load_in, load_pend, pend_wr;
  logic              out_bit_d, out_valid_d, out_last_d;

  // Ready comes from the holding flag (and reset), never from in_valid.
  assign in_ready  = !pend_full && !rst;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state == SHIFT) && (cnt_q == CNT_LAST);
  assign load_pend = last_bit && pend_full;
  assign load_in   = accept && ((state == IDLE) || (last_bit && !pend_full));
  assign pend_wr   = accept && !load_in;
  assign busy      = (state == SHIFT) || pend_full;

  serializer_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pend_wr),
    .wr_data (in_data),
    .rd_en   (load_pend),
    .rd_data (pend_data),
    .full    (pend_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_in) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !load_in && !load_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A queued word wins over a same-cycle bypass; in_ready is low then anyway.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (load_pend) begin
      shift_nxt = pend_data;
      cnt_nxt   = '0;
    end else if (load_in) begin
      shift_nxt = in_data;
      cnt_nxt   = '0;
    end else if (state == SHIFT) begin
      shift_nxt = advance(shift_q);
      cnt_nxt   = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    out_valid_d = (state_nxt == SHIFT);
    out_bit_d   = out_valid_d ? head_bit(shift_nxt) : IDLE_BIT;
    out_last_d  = out_valid_d && (cnt_nxt == CNT_LAST);
  end

  // Output stage: registered copies of the next-cycle bit and frame markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bit   <= IDLE_BIT;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_bit   <= out_bit_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

endmodule
